// File: rtl/add_hdr_pkg.sv
// rtl/add_hdr_pkg.sv - shared IOQ header layout, stage default, ctrl decode and FSM states for add_hdr
package add_hdr_pkg;

  localparam int WORD_LEN_POS = 48;
  localparam int DST_POS      = 32;
  localparam int SRC_POS      = 16;
  localparam int BYTE_LEN_POS = 0;

  localparam logic [7:0] STAGE_NUM_DEFAULT = 8'hff;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_WAIT_D,
    ST_DATA
  } state_t;

  // Lowest set bit marks the last valid byte: bit 0 -> 8 bytes, bit 7 -> 1 byte.
  function automatic logic [3:0] ctrl_to_bytes(input logic [7:0] ctrl);
    ctrl_to_bytes = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (ctrl[i]) ctrl_to_bytes = 4'(8 - i);
    end
  endfunction

endpackage

// File: rtl/add_hdr_if.sv
// rtl/add_hdr_if.sv - word stream bus (data/ctrl/wr/rdy) with master and slave views
interface add_hdr_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;

  modport master (output data, ctrl, wr, input rdy);
  modport slave  (input data, ctrl, wr, output rdy);
endinterface

// File: rtl/add_hdr_fifo.sv
// rtl/add_hdr_fifo.sv - synchronous FIFO with show-ahead read, async reset, empty/full/almost_full
module add_hdr_fifo #(
  parameter int WIDTH      = 72,
  parameter int DEPTH_BITS = 9,
  parameter int AF_FREE    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             almost_full
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_LEVEL = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] AF_LEVEL   = (DEPTH_BITS + 1)'(DEPTH - AF_FREE);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic                  push, pop;

  assign pop         = rd && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
  assign push        = wr && (!full || pop);
  assign empty       = (count == '0);
  assign full        = (count == FULL_LEVEL);
  assign almost_full = (count >= AF_LEVEL);
  assign dout        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/add_hdr.sv
// rtl/add_hdr.sv - store-and-forward stage prepending a length/source header; ADD_HDR_PKT_CNT_EN adds pkt_count
module add_hdr
  import add_hdr_pkg::*;
#(
  parameter int                    DATA_WIDTH           = 64,
  parameter int                    CTRL_WIDTH           = DATA_WIDTH / 8,
  parameter logic [CTRL_WIDTH-1:0] STAGE_NUM            = STAGE_NUM_DEFAULT,
  parameter logic [15:0]           PORT_NUMBER          = 16'd0,
  parameter int                    DATA_FIFO_DEPTH_BITS = 9,
  parameter int                    LEN_FIFO_DEPTH_BITS  = 4
) (
  input  logic     clk,
  input  logic     reset,
  add_hdr_if.slave  rx,
  add_hdr_if.master tx
`ifdef ADD_HDR_PKT_CNT_EN
  ,
  output logic [31:0] pkt_count
`endif
);
  localparam int DW = DATA_WIDTH + CTRL_WIDTH;

  logic [DW-1:0]         data_dout;
  logic [DATA_WIDTH-1:0] hdr_din, hdr_dout;
  logic                  data_empty, data_full, data_af, data_rd;
  logic                  hdr_empty, hdr_full, hdr_af, hdr_rd, hdr_push;
  logic                  is_last, last_out;
  logic [15:0]           word_cnt, word_len, byte_len;
  logic [3:0]            last_bytes;
  state_t                state;
  logic                  unused_flags;

  assign unused_flags = &{1'b0, data_full, hdr_af};

  assign is_last    = |rx.ctrl;
  assign last_out   = |tx.ctrl;
  assign last_bytes = ctrl_to_bytes(rx.ctrl);
  assign word_len   = word_cnt + 16'd1;
  assign byte_len   = {word_cnt[12:0], 3'b000} + {12'd0, last_bytes};
  assign hdr_push   = rx.wr && is_last;
  assign rx.rdy     = !reset && !data_af && !hdr_full;

  always_comb begin
    hdr_din                       = '0;
    hdr_din[WORD_LEN_POS +: 16]   = word_len;
    hdr_din[DST_POS +: 16]        = 16'h0000;
    hdr_din[SRC_POS +: 16]        = PORT_NUMBER;
    hdr_din[BYTE_LEN_POS +: 16]   = byte_len;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      word_cnt <= '0;
    else if (rx.wr) word_cnt <= is_last ? 16'd0 : word_cnt + 16'd1;
  end

  add_hdr_fifo #(.WIDTH(DW), .DEPTH_BITS(DATA_FIFO_DEPTH_BITS), .AF_FREE(2)) data_fifo (
    .clk(clk), .reset(reset), .din({rx.ctrl, rx.data}), .wr(rx.wr), .rd(data_rd),
    .dout(data_dout), .empty(data_empty), .full(data_full), .almost_full(data_af)
  );

  add_hdr_fifo #(.WIDTH(DATA_WIDTH), .DEPTH_BITS(LEN_FIFO_DEPTH_BITS), .AF_FREE(2)) hdr_fifo (
    .clk(clk), .reset(reset), .din(hdr_din), .wr(hdr_push), .rd(hdr_rd),
    .dout(hdr_dout), .empty(hdr_empty), .full(hdr_full), .almost_full(hdr_af)
  );

  // Reads are only issued while downstream is ready; the word shows up registered next cycle.
  always_comb begin
    hdr_rd  = 1'b0;
    data_rd = 1'b0;
    if (tx.rdy) begin
      case (state)
        ST_IDLE:           hdr_rd  = !hdr_empty;
        ST_HDR, ST_WAIT_D: data_rd = !data_empty;
        ST_DATA: begin
          if (last_out) hdr_rd  = !hdr_empty;
          else          data_rd = !data_empty;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      tx.wr   <= 1'b0;
      tx.data <= '0;
      tx.ctrl <= '0;
    end else begin
      tx.wr <= hdr_rd || data_rd;
      if (hdr_rd) begin
        tx.data <= hdr_dout;
        tx.ctrl <= STAGE_NUM;
        state   <= ST_HDR;
      end else if (data_rd) begin
        tx.data <= data_dout[DATA_WIDTH-1:0];
        tx.ctrl <= data_dout[DW-1 -: CTRL_WIDTH];
        state   <= ST_DATA;
      end else if (state == ST_IDLE || (state == ST_DATA && last_out)) begin
        state <= ST_IDLE;
      end else begin
        state <= ST_WAIT_D;
      end
    end
  end

`ifdef ADD_HDR_PKT_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         pkt_count <= '0;
    else if (hdr_push) pkt_count <= pkt_count + 32'd1;
  end
`endif

endmodule
